// File: rtl/lzrw1_item_parser_if.sv
// Byte-stream input and item-stream output bundle of the LZRW1 item parser.
// The slave modport is the parser's view; the master modport is the stream source / item sink.
interface lzrw1_item_parser_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_last;
  logic        byte_ready;
  logic [15:0] item_data;
  logic        item_is_copy;
  logic        item_valid;
  logic        item_last;
  logic        downstream_busy;
  logic        format_error;

  modport slave (
    input  byte_in, byte_valid, byte_last, downstream_busy,
    output byte_ready, item_data, item_is_copy, item_valid, item_last, format_error
  );

  modport master (
    output byte_in, byte_valid, byte_last, downstream_busy,
    input  byte_ready, item_data, item_is_copy, item_valid, item_last, format_error
  );
endinterface

// File: rtl/lzrw1_item_parser.sv
// Splits an LZRW1 compressed byte stream into 16-bit literal/copy items, one
// control bit per item taken from a little-endian 16-bit control word.
module lzrw1_item_parser #(
  parameter int ITEMS_PER_GROUP = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  lzrw1_item_parser_if.slave   bus
);

  localparam int IDX_W = (ITEMS_PER_GROUP > 1) ? $clog2(ITEMS_PER_GROUP) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ITEMS_PER_GROUP - 1);

  localparam logic [2:0] CTRL_LO = 3'd0;
  localparam logic [2:0] CTRL_HI = 3'd1;
  localparam logic [2:0] ITEM_B0 = 3'd2;
  localparam logic [2:0] ITEM_B1 = 3'd3;
  localparam logic [2:0] EMIT    = 3'd4;

  logic [2:0]       state;
  logic [15:0]      ctrl;
  logic [IDX_W-1:0] item_idx;
  logic [15:0]      item_data;
  logic             item_is_copy;
  logic             item_last;
  logic             format_error;
  logic             byte_xfer;
  logic             item_xfer;

  assign bus.byte_ready   = (state != EMIT);
  assign bus.item_valid   = (state == EMIT);
  assign bus.item_data    = item_data;
  assign bus.item_is_copy = item_is_copy;
  assign bus.item_last    = item_last;
  assign bus.format_error = format_error;

  assign byte_xfer = bus.byte_valid && (state != EMIT);
  assign item_xfer = (state == EMIT) && !bus.downstream_busy;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= CTRL_LO;
      ctrl         <= '0;
      item_idx     <= '0;
      item_data    <= '0;
      item_is_copy <= 1'b0;
      item_last    <= 1'b0;
      format_error <= 1'b0;
    end else begin
      case (state)
        CTRL_LO: if (byte_xfer) begin
          // A stream cannot end on the first half of a control word.
          if (bus.byte_last) begin
            format_error <= 1'b1;
          end else begin
            ctrl[7:0] <= bus.byte_in;
            state     <= CTRL_HI;
          end
        end
        CTRL_HI: if (byte_xfer) begin
          ctrl[15:8] <= bus.byte_in;
          item_idx   <= '0;
          state      <= bus.byte_last ? CTRL_LO : ITEM_B0;
        end
        ITEM_B0: if (byte_xfer) begin
          if (!ctrl[item_idx]) begin
            item_data    <= {8'h00, bus.byte_in};
            item_is_copy <= 1'b0;
            item_last    <= bus.byte_last;
            state        <= EMIT;
          end else if (bus.byte_last) begin
            // Half a copy item: drop it and wait for a fresh control word.
            format_error <= 1'b1;
            state        <= CTRL_LO;
          end else begin
            item_data[15:8] <= bus.byte_in;
            state           <= ITEM_B1;
          end
        end
        ITEM_B1: if (byte_xfer) begin
          item_data[7:0] <= bus.byte_in;
          item_is_copy   <= 1'b1;
          item_last      <= bus.byte_last;
          state          <= EMIT;
        end
        EMIT: if (item_xfer) begin
          if (item_last || (item_idx == LAST_IDX)) begin
            state <= CTRL_LO;
          end else begin
            item_idx <= item_idx + 1'b1;
            state    <= ITEM_B0;
          end
        end
        default: state <= CTRL_LO;
      endcase
    end
  end

endmodule

// File: tb/tb_lzrw1_item_parser.sv
// Self-checking bench for lzrw1_item_parser: cycle vectors, directed corner
// sequences, and a random byte stream compared against a stream-level parse model.
module tb_lzrw1_item_parser;

  localparam int GROUP = 16;

  logic clock;
  logic reset;
  lzrw1_item_parser_if bus ();

  lzrw1_item_parser #(.ITEMS_PER_GROUP(GROUP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  b;
    logic        v;
    logic        l;
    logic        busy;
    logic        e_rdy;
    logic        e_iv;
    logic [15:0] e_data;
    logic        e_copy;
    logic        e_last;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic        c;
    logic        l;
  } item_t;

  vec_t  tbl[$];
  item_t exp_q[$];
  logic  exp_err;
  logic [7:0] rb[$];
  logic       rl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    bus.byte_valid      = 1'b0;
    bus.byte_last       = 1'b0;
    bus.byte_in         = 8'h00;
    bus.downstream_busy = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // Starts just after a falling edge; returns just after the next falling edge.
  task automatic put(input logic [7:0] b, input logic l);
    int w;
    bus.byte_in    = b;
    bus.byte_last  = l;
    bus.byte_valid = 1'b1;
    #1;
    w = 0;
    while (!bus.byte_ready && w < 20) begin
      @(negedge clock);
      #1;
      w++;
    end
    if (w >= 20) chk("put byte timeout", 32'(w), 32'(0));
    @(posedge clock);
    @(negedge clock);
    bus.byte_valid = 1'b0;
    bus.byte_last  = 1'b0;
  endtask

  task automatic expect_item(input string name, input logic [15:0] d, input logic c, input logic l);
    #1;
    chk({name, " valid"}, 32'(bus.item_valid), 32'(1));
    chk({name, " data"},  32'(bus.item_data), 32'(d));
    chk({name, " copy"},  32'(bus.item_is_copy), 32'(c));
    chk({name, " last"},  32'(bus.item_last), 32'(l));
    @(posedge clock);
    @(negedge clock);
  endtask

  // Parse the whole byte stream into the item list it should yield.
  function automatic void build_model();
    int n;
    int i;
    logic [15:0] c;
    logic stop;
    n = rb.size();
    i = 0;
    exp_q.delete();
    exp_err = 1'b0;
    while (i < n) begin
      if (rl[i]) begin
        exp_err = 1'b1;
        i++;
        continue;
      end
      if (i + 1 >= n) break;
      c    = {rb[i+1], rb[i]};
      stop = rl[i+1];
      i   += 2;
      for (int k = 0; k < GROUP && !stop && i < n; k++) begin
        if (!c[k]) begin
          exp_q.push_back(item_t'{{8'h00, rb[i]}, 1'b0, rl[i]});
          stop = rl[i];
          i++;
        end else if (rl[i]) begin
          exp_err = 1'b1;
          stop = 1'b1;
          i++;
        end else if (i + 1 >= n) begin
          i = n;
        end else begin
          exp_q.push_back(item_t'{{rb[i], rb[i+1]}, 1'b1, rl[i+1]});
          stop = rl[i+1];
          i += 2;
        end
      end
    end
  endfunction

  initial begin
    int pos;
    int cyc;
    item_t it;

    clock = 1'b0;
    reset = 1'b0;
    bus.byte_in = 8'h00; bus.byte_valid = 1'b0; bus.byte_last = 1'b0; bus.downstream_busy = 1'b0;

    // Reset state
    #2;
    chk("rst item_valid", 32'(bus.item_valid), 32'(0));
    chk("rst item_data",  32'(bus.item_data), 32'(0));
    chk("rst item_copy",  32'(bus.item_is_copy), 32'(0));
    chk("rst item_last",  32'(bus.item_last), 32'(0));
    chk("rst format_err", 32'(bus.format_error), 32'(0));
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst byte_ready", 32'(bus.byte_ready), 32'(1));
    @(negedge clock);

    // Cycle vectors: copy+literal, last literal with stall, copy error, empty group
    //                 b      v     l     busy  rdy   iv    data      copy  last  err
    tbl.push_back(vec_t'{8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{8'h3A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{8'hBC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{8'h43, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h3ABC, 1'b1, 1'b0, 1'b0});
    tbl.push_back(vec_t'{8'h43, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0043, 1'b0, 1'b1, 1'b0});
    tbl.push_back(vec_t'{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{8'h55, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0055, 1'b0, 1'b1, 1'b0});
    tbl.push_back(vec_t'{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0055, 1'b0, 1'b1, 1'b0});
    tbl.push_back(vec_t'{8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{8'h3A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1});
    tbl.push_back(vec_t'{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1});
    tbl.push_back(vec_t'{8'h77, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1});
    tbl.push_back(vec_t'{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0077, 1'b0, 1'b1, 1'b1});
    tbl.push_back(vec_t'{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1});
    tbl.push_back(vec_t'{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1});
    tbl.push_back(vec_t'{8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1});
    tbl.push_back(vec_t'{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1});
    tbl.push_back(vec_t'{8'h88, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1});
    tbl.push_back(vec_t'{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1});

    for (int i = 0; i < tbl.size(); i++) begin
      bus.byte_in         = tbl[i].b;
      bus.byte_valid      = tbl[i].v;
      bus.byte_last       = tbl[i].l;
      bus.downstream_busy = tbl[i].busy;
      #1;
      chk($sformatf("vec%0d byte_ready", i), 32'(bus.byte_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d item_valid", i), 32'(bus.item_valid), 32'(tbl[i].e_iv));
      chk($sformatf("vec%0d format_error", i), 32'(bus.format_error), 32'(tbl[i].e_err));
      if (tbl[i].e_iv) begin
        chk($sformatf("vec%0d item_data", i), 32'(bus.item_data), 32'(tbl[i].e_data));
        chk($sformatf("vec%0d item_is_copy", i), 32'(bus.item_is_copy), 32'(tbl[i].e_copy));
        chk($sformatf("vec%0d item_last", i), 32'(bus.item_last), 32'(tbl[i].e_last));
      end
      @(posedge clock);
      @(negedge clock);
    end
    bus.byte_valid = 1'b0;
    bus.byte_last  = 1'b0;
    bus.downstream_busy = 1'b0;

    // Full group of 16 literals at full rate, then a fresh control word
    do_reset();
    put(8'h00, 1'b0);
    put(8'h00, 1'b0);
    for (int k = 0; k < 16; k++) begin
      #1;
      chk($sformatf("lit%0d byte_ready", k), 32'(bus.byte_ready), 32'(1));
      put(8'(8'h41 + k), 1'b0);
      expect_item($sformatf("lit%0d", k), {8'h00, 8'(8'h41 + k)}, 1'b0, 1'b0);
    end
    put(8'h03, 1'b0);
    #1;
    chk("after group byte is ctrl", 32'(bus.item_valid), 32'(0));
    @(negedge clock);
    put(8'h00, 1'b0);
    put(8'h99, 1'b0);
    #1;
    chk("copy first byte no item", 32'(bus.item_valid), 32'(0));
    chk("copy first byte ready", 32'(bus.byte_ready), 32'(1));
    @(negedge clock);

    // Downstream stall held for 5 cycles in EMIT
    do_reset();
    put(8'h00, 1'b0);
    put(8'h00, 1'b0);
    put(8'h66, 1'b0);
    bus.downstream_busy = 1'b1;
    bus.byte_in    = 8'h67;
    bus.byte_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("stall%0d item_valid", k), 32'(bus.item_valid), 32'(1));
      chk($sformatf("stall%0d item_data", k), 32'(bus.item_data), 32'(16'h0066));
      chk($sformatf("stall%0d byte_ready", k), 32'(bus.byte_ready), 32'(0));
      @(posedge clock);
      @(negedge clock);
    end
    bus.downstream_busy = 1'b0;
    #1;
    chk("stall release valid", 32'(bus.item_valid), 32'(1));
    chk("stall release data", 32'(bus.item_data), 32'(16'h0066));
    @(posedge clock);
    @(negedge clock);
    #1;
    chk("stall single transfer", 32'(bus.item_valid), 32'(0));
    chk("stall next ready", 32'(bus.byte_ready), 32'(1));
    @(posedge clock);
    @(negedge clock);
    bus.byte_valid = 1'b0;
    expect_item("after stall", 16'h0067, 1'b0, 1'b0);

    // Reset pulsed while in ITEM_B1
    do_reset();
    put(8'h01, 1'b0);
    put(8'h00, 1'b0);
    put(8'h3A, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("midreset item_valid", 32'(bus.item_valid), 32'(0));
    chk("midreset item_data", 32'(bus.item_data), 32'(0));
    chk("midreset item_copy", 32'(bus.item_is_copy), 32'(0));
    chk("midreset item_last", 32'(bus.item_last), 32'(0));
    chk("midreset format_err", 32'(bus.format_error), 32'(0));
    chk("midreset byte_ready", 32'(bus.byte_ready), 32'(1));
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      #1;
      chk($sformatf("postreset idle%0d", k), 32'(bus.item_valid), 32'(0));
    end
    @(negedge clock);
    put(8'h00, 1'b0);
    put(8'h00, 1'b0);
    put(8'h55, 1'b1);
    expect_item("postreset lit", 16'h0055, 1'b0, 1'b1);

    // Random stream against the stream-level model
    do_reset();
    rb.delete();
    rl.delete();
    for (int i = 0; i < 700; i++) begin
      rb.push_back(8'($urandom));
      rl.push_back($urandom_range(0, 14) == 0);
    end
    build_model();
    pos = 0;
    cyc = 0;
    while (cyc < 20000) begin
      @(negedge clock);
      if (pos >= rb.size() && !bus.item_valid) break;
      bus.downstream_busy = ($urandom_range(0, 3) == 0);
      if (pos < rb.size() && $urandom_range(0, 3) != 0) begin
        bus.byte_valid = 1'b1;
        bus.byte_in    = rb[pos];
        bus.byte_last  = rl[pos];
      end else begin
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
      end
      #1;
      if (bus.byte_valid && bus.byte_ready) pos++;
      if (bus.item_valid && !bus.downstream_busy) begin
        if (exp_q.size() == 0) begin
          chk("rand unexpected item", 32'(bus.item_data), 32'hFFFF_FFFF);
        end else begin
          it = exp_q.pop_front();
          chk("rand item_data", 32'(bus.item_data), 32'(it.d));
          chk("rand item_is_copy", 32'(bus.item_is_copy), 32'(it.c));
          chk("rand item_last", 32'(bus.item_last), 32'(it.l));
        end
      end
      cyc++;
    end
    bus.byte_valid = 1'b0;
    bus.downstream_busy = 1'b0;
    chk("rand finished in budget", 32'(cyc < 20000), 32'(1));
    chk("rand items left", 32'(exp_q.size()), 32'(0));
    chk("rand format_error", 32'(bus.format_error), 32'(exp_err));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lzrw1_item_parser.md
LZRW1_ITEM_PARSER -- requirements
Module: lzrw1_item_parser

Interface
REQ-001 Parameter ITEMS_PER_GROUP, default 16, number of items governed by one control word (one control bit per item).
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 byte_in  input  8  compressed stream byte.
REQ-005 byte_valid  input  1  byte_in holds a valid byte this cycle.
REQ-006 byte_last  input  1  qualifies byte_in as the final byte of the stream; meaningful only when byte_valid=1.
REQ-007 byte_ready  output  1  parser accepts byte_in this cycle.
REQ-008 item_data  output  16  item for the decompressor: literal = {8'h00, byte}; copy = {length[3:0], offset[11:0]}.
REQ-009 item_is_copy  output  1  control bit for item_data (0 literal, 1 copy); drives the decompressor's control_word_in.
REQ-010 item_valid  output  1  item_data/item_is_copy valid; drives the decompressor's in_data_valid.
REQ-011 item_last  output  1  item is the last item of the stream; valid with item_valid.
REQ-012 downstream_busy  input  1  decompressor busy; item not accepted while 1.
REQ-013 format_error  output  1  sticky malformed-stream flag.

Function
REQ-014 A byte transfers on a cycle with byte_valid=1 and byte_ready=1; an item transfers on a cycle with item_valid=1 and downstream_busy=0.
REQ-015 States: CTRL_LO, CTRL_HI, ITEM_B0, ITEM_B1, EMIT; byte_ready=1 in all states except EMIT; item_valid=1 only in EMIT.
REQ-016 CTRL_LO: on a byte transfer, store byte as ctrl[7:0] -> CTRL_HI.
REQ-017 CTRL_HI: on a byte transfer, store byte as ctrl[15:8], clear item_idx to 0 -> ITEM_B0.
REQ-018 ITEM_B0 with ctrl[item_idx]=0: on a byte transfer, load item_data={8'h00,byte_in}, item_is_copy=0 -> EMIT.
REQ-019 ITEM_B0 with ctrl[item_idx]=1: on a byte transfer, store byte_in as item_data[15:8] ({length, offset[11:8]}) -> ITEM_B1.
REQ-020 ITEM_B1: on a byte transfer, load item_data[7:0]=byte_in, item_is_copy=1 -> EMIT.
REQ-021 EMIT: item_data, item_is_copy, item_last held stable until transfer; on transfer -> CTRL_LO if item_last=1 or item_idx=ITEMS_PER_GROUP-1, else item_idx+1 and -> ITEM_B0.
REQ-022 Minimum latency: last byte of an item accepted in cycle N -> item_valid=1 in cycle N+1; an item accepted in cycle N with downstream_busy=0 lets the next byte be accepted in cycle N+1.
REQ-023 item_last=1 when the byte completing the item had byte_last=1.
REQ-024 byte_last on CTRL_HI byte: legal, group ends with zero items -> CTRL_LO, no item emitted.
REQ-025 byte_last on CTRL_LO byte, or on ITEM_B0 byte of a copy item: set format_error, discard partial data -> CTRL_LO, no item emitted.
REQ-026 Items are never dropped or duplicated; the length and offset fields are passed unmodified (no arithmetic on them).
REQ-027 item_idx is $clog2(ITEMS_PER_GROUP) bits wide and wraps to 0 only via a new control word.
REQ-028 format_error, once set, stays 1 until reset; parsing continues normally after it.

Reset
REQ-029 reset=0 asynchronously forces CTRL_LO, item_idx=0, ctrl=0, item_data=0, item_is_copy=0, item_last=0, item_valid=0, format_error=0; byte_ready=1 in the first cycle after release.
REQ-030 Reset asserted mid-item or in EMIT discards the pending item; no item_valid pulse on or after release until new bytes arrive.

Verification
REQ-031 Bytes 00 00 41 42 … (16 literals), downstream_busy=0 -> 16 items {00,41},{00,42},…, item_is_copy=0, then CTRL_LO.
REQ-032 Control 01 00, bytes 3A BC, 43 -> item 16'h3ABC copy (length 3, offset 0xABC), then item 16'h0043 literal.
REQ-033 downstream_busy=1 for 5 cycles during EMIT -> item_valid and item_data stay stable, byte_ready=0, no extra byte consumed; one transfer when busy drops.
REQ-034 Control 00 00, literal 55 with byte_last=1 -> single item 16'h0055 with item_last=1, state returns to CTRL_LO.
REQ-035 Control 01 00, byte 3A with byte_last=1 -> format_error=1, no item emitted, next stream parses correctly with format_error still 1.
REQ-036 reset pulsed while in ITEM_B1 -> all outputs at REQ-029 values, next two bytes are parsed as a control word.
